lfsr64_checker: RTL and testbench
=================================

Name: lfsr64_checker

Overview:
- Self-checking consumer placed directly downstream of the 64-bit XNOR LFSR test generator.
- Samples the LFSR state word every valid cycle and predicts the next word from the previous one.
- Acquires and tracks lock, and counts mismatches once locked.
- Flags the XNOR lock-up state (all ones).
- Status outputs drive lights on the placed test board, so a bad build shows as a visible ERROR lamp.

Parameters:
- LOCK_CNT, 4: consecutive matching samples needed to enter LOCK (legal range 1..255).
- LOSE_CNT, 3: consecutive mismatching samples in LOCK that drop back to ACQ (legal range 1..255).
- ERR_W, 16: width of the saturating error counter (legal range 1..32).

Ports:
- CLK, input, 1: clock, rising edge; same clock as the LFSR.
- RST, input, 1: synchronous, active-high reset.
- DIN, input, 64: LFSR state word under test.
- DIN_VALID, input, 1: DIN is a valid sample this cycle. Tie to ~RST of the LFSR in normal use.
- LOCKED, output, 1: checker is in the LOCK state.
- ERROR, output, 1: sticky; set on any mismatch while in LOCK.
- STUCK, output, 1: last valid sample was all ones (XNOR lock-up state).
- ERR_COUNT, output, ERR_W: saturating count of mismatches seen in LOCK.

Behaviour:
- Reset: RST is synchronous and active-high; the clock is CLK. RST=1 at any rising edge, including mid-operation, forces:
  - state to EMPTY; prev, match_run and miss_run to 0;
  - LOCKED, ERROR, STUCK to 0 and ERR_COUNT to 0.
  - RST overrides DIN_VALID.
- Prediction: nxt(p) = {p[0]^p[8]^p[13]^p[31]^1, p[63:1]}. match = (DIN == nxt(prev)).
- DIN_VALID=0: all state, counters and outputs hold.
- Every valid sample loads prev <= DIN, in every state and whether it matched or not. STUCK <= (DIN == all ones).
- All outputs are registered. A sample taken at edge N is reflected on the outputs after edge N; there are no combinational paths from DIN to any output.
- State machine (updates on valid samples only):
  - EMPTY: capture prev, go to ACQ with match_run=0. No comparison is made.
  - ACQ:
    - match: match_run+1; on reaching LOCK_CNT, go to LOCK with miss_run=0 and match_run=0.
    - mismatch: match_run=0, stay in ACQ (resynchronise on the new prev).
    - ERR_COUNT and ERROR are never touched in ACQ.
  - LOCK:
    - match: miss_run=0.
    - mismatch: ERROR<=1, ERR_COUNT+1 (saturates at 2^ERR_W-1, never wraps), miss_run+1. On reaching LOSE_CNT, go to ACQ with match_run=0.
  - LOCKED = (state==LOCK).
- A single corrupted word yields two mismatches: bad word vs. prediction, then the next good word vs. the bad prev. This is by design.
- All-ones input predicts all ones, so a stuck LFSR still locks. STUCK is the only indication of lock-up.
- All-zeros (the LFSR reset value) is a legal state; its successor is 0x8000_0000_0000_0000.
- Counter widths: match_run and miss_run are 8 bits.

Test Plan:
1. Lock acquisition:
   - Stimulus: RST, then valid DIN = 0, 0x8000000000000000, 0xC000000000000000, 0xE000000000000000, 0xF000000000000000.
   - Required: LOCKED=0 through the 4th sample; LOCKED=1 after the 5th; ERROR=0; ERR_COUNT=0.
2. Single glitch in lock (LOSE_CNT=3):
   - Stimulus: after scenario 1, feed 0x0 instead of 0xF800000000000000, then a correct continuation.
   - Required: ERROR=1, ERR_COUNT=2, LOCKED stays 1.
3. Lock loss:
   - Stimulus: three consecutive non-sequence words while locked.
   - Required: ERR_COUNT +3 and LOCKED=0 after the third; a subsequent good sequence relocks after 4 matches with ERROR still 1.
4. Stuck state:
   - Stimulus: 0xFFFFFFFFFFFFFFFF repeated 5 times from reset.
   - Required: STUCK=1 from the first sample, LOCKED=1 after the 5th, ERROR=0. A following 0x0 sample clears STUCK.
5. Saturation and gaps (ERR_W=2, LOSE_CNT=8):
   - Stimulus: lock, then 5 mismatches interleaved with DIN_VALID=0 cycles carrying garbage DIN.
   - Required: ERR_COUNT=3 (saturated), LOCKED=1, and no change on invalid cycles.
6. Reset mid-operation:
   - Stimulus: assert RST for 1 cycle while locked with ERR_COUNT=2.
   - Required: next cycle LOCKED=0, ERROR=0, STUCK=0, ERR_COUNT=0. The first valid sample after reset is capture-only (no error on any value).

Source files
------------

// File: rtl/lfsr64_checker.sv
// Self-checking consumer for the 64-bit XNOR LFSR generator: predicts each word
// from the previous one, tracks lock, counts in-lock mismatches and flags lock-up.
module lfsr64_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSE_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [63:0]      DIN,
    input  logic             DIN_VALID,
    output logic             LOCKED,
    output logic             ERROR,
    output logic             STUCK,
    output logic [ERR_W-1:0] ERR_COUNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACQ   = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
    localparam logic [7:0] LOSE_C = 8'(LOSE_CNT);

    state_t      state;
    logic [63:0] prev;
    logic [7:0]  match_run;
    logic [7:0]  miss_run;
    logic        match;

    function automatic logic [63:0] nxt(input logic [63:0] p);
        return {p[0] ^ p[8] ^ p[13] ^ p[31] ^ 1'b1, p[63:1]};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign match = (DIN == nxt(prev));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= EMPTY;
            prev      <= '0;
            match_run <= '0;
            miss_run  <= '0;
            LOCKED    <= 1'b0;
            ERROR     <= 1'b0;
            STUCK     <= 1'b0;
            ERR_COUNT <= '0;
        end else if (DIN_VALID) begin
            prev  <= DIN;
            STUCK <= &DIN;
            case (state)
                EMPTY: begin
                    state     <= ACQ;
                    match_run <= '0;
                end
                ACQ: begin
                    if (!match) begin
                        match_run <= '0;
                    end else if (match_run + 8'd1 == LOCK_C) begin
                        state     <= LOCK;
                        LOCKED    <= 1'b1;
                        match_run <= '0;
                        miss_run  <= '0;
                    end else begin
                        match_run <= match_run + 8'd1;
                    end
                end
                LOCK: begin
                    if (match) begin
                        miss_run <= '0;
                    end else begin
                        ERROR     <= 1'b1;
                        ERR_COUNT <= sat_inc(ERR_COUNT);
                        // Too many misses in a row: the stream moved on, re-acquire.
                        if (miss_run + 8'd1 == LOSE_C) begin
                            state     <= ACQ;
                            LOCKED    <= 1'b0;
                            match_run <= '0;
                            miss_run  <= '0;
                        end else begin
                            miss_run <= miss_run + 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= EMPTY;
                    LOCKED <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr64_checker.sv
// Directed bench for lfsr64_checker: a vector table on the default build plus a
// hand-written saturation/gap sequence on a narrow-counter build.
module tb_lfsr64_checker;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [63:0] DIN = '0;
    logic        DIN_VALID = 1'b0;

    logic        a_locked, a_error, a_stuck;
    logic [15:0] a_cnt;
    logic        b_locked, b_error, b_stuck;
    logic [1:0]  b_cnt;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    lfsr64_checker #(.LOCK_CNT(4), .LOSE_CNT(3), .ERR_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .LOCKED(a_locked), .ERROR(a_error), .STUCK(a_stuck), .ERR_COUNT(a_cnt)
    );

    lfsr64_checker #(.LOCK_CNT(4), .LOSE_CNT(8), .ERR_W(2)) dut_b (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .LOCKED(b_locked), .ERROR(b_error), .STUCK(b_stuck), .ERR_COUNT(b_cnt)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [63:0] din;
        logic        lk;
        logic        er;
        logic        st;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] W0  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] W8  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] WC  = 64'hC000_0000_0000_0000;
    localparam logic [63:0] WE  = 64'hE000_0000_0000_0000;
    localparam logic [63:0] WF  = 64'hF000_0000_0000_0000;
    localparam logic [63:0] WFC = 64'hFC00_0000_0000_0000;
    localparam logic [63:0] WFE = 64'hFE00_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] JUNK = 64'h0000_0000_0000_1234;

    task automatic add(input logic r, input logic v, input logic [63:0] d,
                       input logic lk, input logic er, input logic st, input logic [15:0] c);
        vec_t e;
        e.rst = r; e.vld = v; e.din = d; e.lk = lk; e.er = er; e.st = st; e.cnt = c;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic v, input logic [63:0] d);
        @(negedge CLK);
        RST = r; DIN_VALID = v; DIN = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset state
        add(1, 0, W0,   0, 0, 0, 0);
        // lock acquisition
        add(0, 1, W0,   0, 0, 0, 0);
        add(0, 1, W8,   0, 0, 0, 0);
        add(0, 1, WC,   0, 0, 0, 0);
        add(0, 1, WE,   0, 0, 0, 0);
        add(0, 1, WF,   1, 0, 0, 0);
        // single glitch: bad word, then the true continuation
        add(0, 1, W0,   1, 1, 0, 1);
        add(0, 1, WFC,  1, 1, 0, 2);
        add(0, 1, WFE,  1, 1, 0, 2);
        add(0, 0, ONES, 1, 1, 0, 2);
        // lock loss and relock
        add(0, 1, JUNK, 1, 1, 0, 3);
        add(0, 1, JUNK, 1, 1, 0, 4);
        add(0, 1, JUNK, 0, 1, 0, 5);
        add(0, 1, W0,   0, 1, 0, 5);
        add(0, 1, W8,   0, 1, 0, 5);
        add(0, 1, WC,   0, 1, 0, 5);
        add(0, 1, WE,   0, 1, 0, 5);
        add(0, 1, WF,   1, 1, 0, 5);
        // stuck all-ones stream
        add(1, 0, W0,   0, 0, 0, 0);
        add(0, 1, ONES, 0, 0, 1, 0);
        add(0, 1, ONES, 0, 0, 1, 0);
        add(0, 1, ONES, 0, 0, 1, 0);
        add(0, 1, ONES, 0, 0, 1, 0);
        add(0, 1, ONES, 1, 0, 1, 0);
        add(0, 1, W0,   1, 1, 0, 1);
        // reset mid-operation with ERR_COUNT=2
        add(1, 0, W0,   0, 0, 0, 0);
        add(0, 1, W0,   0, 0, 0, 0);
        add(0, 1, W8,   0, 0, 0, 0);
        add(0, 1, WC,   0, 0, 0, 0);
        add(0, 1, WE,   0, 0, 0, 0);
        add(0, 1, WF,   1, 0, 0, 0);
        add(0, 1, W0,   1, 1, 0, 1);
        add(0, 1, WFC,  1, 1, 0, 2);
        add(1, 1, WFE,  0, 0, 0, 0);
        add(0, 1, JUNK, 0, 0, 0, 0);
        add(0, 1, 64'h5555, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].din);
            chk($sformatf("v%0d LOCKED", i),    64'(a_locked), 64'(tbl[i].lk));
            chk($sformatf("v%0d ERROR", i),     64'(a_error),  64'(tbl[i].er));
            chk($sformatf("v%0d STUCK", i),     64'(a_stuck),  64'(tbl[i].st));
            chk($sformatf("v%0d ERR_COUNT", i), 64'(a_cnt),    64'(tbl[i].cnt));
        end

        // saturation with invalid gaps on the 2-bit counter build
        step(1, 0, W0);
        chk("sat reset ERR_COUNT", 64'(b_cnt), 64'd0);
        step(0, 1, W0);
        step(0, 1, W8);
        step(0, 1, WC);
        step(0, 1, WE);
        step(0, 1, WF);
        chk("sat locked", 64'(b_locked), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, JUNK);
            chk($sformatf("sat miss%0d ERR_COUNT", i), 64'(b_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
            chk($sformatf("sat miss%0d LOCKED", i), 64'(b_locked), 64'd1);
            step(0, 0, ONES);
            chk($sformatf("sat gap%0d ERR_COUNT", i), 64'(b_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
            chk($sformatf("sat gap%0d STUCK", i), 64'(b_stuck), 64'd0);
            chk($sformatf("sat gap%0d LOCKED", i), 64'(b_locked), 64'd1);
        end
        chk("sat ERROR", 64'(b_error), 64'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
